// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, issues RAM reads, and holds the returned
// word for decode behind a valid/ready handshake. Supports branch redirect and halt.
module instruction_fetch #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     ADDR_WIDTH  = 16,
  parameter int                     MEM_LATENCY = 1,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [31:0]            HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  output logic                  Enable,
  output logic                  RW,
  output logic [ADDR_WIDTH-1:0] Address_out,
  input  logic [31:0]           Mem_data,
  output logic [31:0]           Instr,
  output logic                  Instr_valid,
  input  logic                  Instr_ready,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic                  Branch_en,
  input  logic [PC_WIDTH-1:0]   Branch_target,
  output logic                  Halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  // Counter value on the last cycle of a fetch, i.e. the edge where Mem_data is sampled.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]         instr_reg, instr_next;
  logic                valid_reg, valid_next;
  logic                halted_reg, halted_next;
  logic [3:0]          cnt_reg, cnt_next;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      valid_reg    <= 1'b0;
      halted_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
      halted_reg   <= halted_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    halted_next   = halted_reg;
    cnt_next      = cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (Run) state_next = FETCH;
      end
      FETCH: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (Mem_data == HALT_WORD) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            instr_next    = Mem_data;
            pc_next       = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + PC_WIDTH'(1);
            valid_next    = 1'b1;
            state_next    = HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      HOLD: begin
        if (Instr_ready) begin
          valid_next = 1'b0;
          state_next = Run ? FETCH : IDLE;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything, including a fetch completing on this same edge.
    if (Branch_en) begin
      fetch_pc_next = Branch_target;
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      valid_next    = 1'b0;
      halted_next   = 1'b0;
      cnt_next      = '0;
      state_next    = Run ? FETCH : IDLE;
    end
  end

  assign Enable      = (state_reg == FETCH);
  assign RW          = 1'b1;
  assign Address_out = ADDR_WIDTH'(fetch_pc_reg);
  assign Instr       = instr_reg;
  assign Instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign Halted      = halted_reg;

endmodule
